// File: rtl/mdu_pkg.sv
// Shared definitions for the sequential multiply unit and its HI/LO register pair.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;
  localparam int MUL_ITERS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIN  = 2'b10
  } state_t;

endpackage

// File: rtl/hilo_regs.sv
// Architectural HI/LO pair: product write port, mthi/mtlo write port and read mux.
module hilo_regs
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               prod_we,
  input  logic [2*WIDTH-1:0] prod,
  input  logic               hi_we,
  input  logic               lo_we,
  input  logic [WIDTH-1:0]   wd,
  input  logic               hilo_sel,
  output logic [WIDTH-1:0]   rd
);

  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;

  // HI/LO update; the product port and the move port are never enabled together
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_r <= {WIDTH{1'b0}};
      lo_r <= {WIDTH{1'b0}};
    end else if (prod_we) begin
      hi_r <= prod[2*WIDTH-1:WIDTH];
      lo_r <= prod[WIDTH-1:0];
    end else begin
      if (hi_we) begin
        hi_r <= wd;
      end else begin
        hi_r <= hi_r;
      end
      if (lo_we) begin
        lo_r <= wd;
      end else begin
        lo_r <= lo_r;
      end
    end
  end

  // Zero-latency read of the selected register
  always_comb begin
    if (hilo_sel) begin
      rd = hi_r;
    end else begin
      rd = lo_r;
    end
  end

endmodule

// File: rtl/mdu_hilo.sv
// Shift-add 32-iteration multiply engine (MULT/MULTU) feeding the HI/LO pair.
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wd,
  input  logic             hilo_sel,
  output logic [WIDTH-1:0] rd,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(MUL_ITERS);

  state_t             state_r, state_s;
  logic [2*WIDTH-1:0] acc_r;
  logic [WIDTH-1:0]   mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic               neg_r;
  logic [CW-1:0]      cnt_r;
  logic               done_r;
  logic [WIDTH:0]     sum_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   a_mag_s;
  logic [WIDTH-1:0]   b_mag_s;
  logic               idle_s;

  assign idle_s = (state_r == IDLE);
  assign busy   = ~idle_s;
  assign done   = done_r;

  // Next-state selection
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = RUN;
        else       state_s = IDLE;
      end
      RUN: begin
        if (cnt_r == CW'(MUL_ITERS - 1)) state_s = FIN;
        else                             state_s = RUN;
      end
      FIN:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Operand magnitudes, partial-sum adder and final sign fix-up
  always_comb begin
    a_mag_s = a;
    b_mag_s = b;
    if (is_signed && a[WIDTH-1]) a_mag_s = ~a + {{(WIDTH-1){1'b0}}, 1'b1};
    else                         a_mag_s = a;
    if (is_signed && b[WIDTH-1]) b_mag_s = ~b + {{(WIDTH-1){1'b0}}, 1'b1};
    else                         b_mag_s = b;
    if (mplier_r[0]) sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, mcand_r};
    else             sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
    if (neg_r) prod_s = ~acc_r + {{(2*WIDTH-1){1'b0}}, 1'b1};
    else       prod_s = acc_r;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // Engine datapath; the carry out of the upper-half add becomes the new MSB
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r    <= {(2*WIDTH){1'b0}};
      mcand_r  <= {WIDTH{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      neg_r    <= 1'b0;
      cnt_r    <= {CW{1'b0}};
      done_r   <= 1'b0;
    end else begin
      done_r <= (state_r == FIN);
      case (state_r)
        IDLE: begin
          if (start) begin
            mcand_r  <= a_mag_s;
            mplier_r <= b_mag_s;
            neg_r    <= (a[WIDTH-1] ^ b[WIDTH-1]) & is_signed;
            acc_r    <= {(2*WIDTH){1'b0}};
            cnt_r    <= {CW{1'b0}};
          end
        end
        RUN: begin
          acc_r    <= {sum_s, acc_r[WIDTH-1:1]};
          mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
          cnt_r    <= cnt_r + CW'(1);
        end
        default: begin
          acc_r <= acc_r;
        end
      endcase
    end
  end

  hilo_regs #(.WIDTH(WIDTH)) u_hilo_regs (
    .clk      (clk),
    .rst      (rst),
    .prod_we  (state_r == FIN),
    .prod     (prod_s),
    .hi_we    (hi_we & idle_s),
    .lo_we    (lo_we & idle_s),
    .wd       (wd),
    .hilo_sel (hilo_sel),
    .rd       (rd)
  );

endmodule

// File: doc/mdu_hilo.md
# mdu_hilo

Sequential multiply unit with the architectural HI/LO register pair for the MIPS datapath. It sits directly downstream of the execute-stage operand registers and replaces the combinational 32x32 product path with a 32-iteration shift-add engine whose 64-bit result lands in HI/LO. It also serves mthi/mtlo writes and mfhi/mflo reads, and exposes `busy` so the hazard unit can stall dependent instructions.

## Interface
- `WIDTH`, 32, operand width; HI/LO are WIDTH each, product is 2*WIDTH.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a multiply with `a`, `b`; sampled only in IDLE.
- `is_signed`  in  1  1 = MULT (two's complement), 0 = MULTU; sampled with `start`.
- `a`  in  WIDTH  multiplicand.
- `b`  in  WIDTH  multiplier.
- `hi_we`  in  1  mthi write enable.
- `lo_we`  in  1  mtlo write enable.
- `wd`  in  WIDTH  mthi/mtlo write data.
- `hilo_sel`  in  1  read select: 0 = LO, 1 = HI.
- `rd`  out  WIDTH  combinational read of the selected register.
- `busy`  out  1  multiply in progress.
- `done`  out  1  one-cycle pulse: HI/LO updated with a new product.

## Operation
- States: IDLE, RUN, FIN.
- IDLE: on `start`, latch magnitudes |a|, |b| (raw values when `is_signed`=0), latch result sign = a[31]^b[31] & is_signed, clear 64-bit accumulator, set count to 0, go to RUN.
- RUN: each cycle, if multiplier bit 0 is set, add multiplicand into accumulator upper half (WIDTH+1-bit add, carry kept); shift accumulator/multiplier right by 1; increment count. After iteration 32 (count = 31 on that edge), go to FIN.
- FIN: write accumulator (two's-complement negated over 64 bits if sign set) to {HI, LO}; pulse `done`; return to IDLE.
- Magnitude of 0x80000000 is 0x80000000 as unsigned; no overflow special case.
- `start` in RUN/FIN: ignored (no queuing).
- `hi_we`/`lo_we` in IDLE: write `wd` to HI/LO on the edge. In RUN/FIN: ignored.
- `start` together with `hi_we`/`lo_we` in IDLE: write applied, multiply starts; product overwrites both registers at FIN.
- `rd` reflects current HI/LO; while `busy`, old values are returned (hazard unit stalls mfhi/mflo on `busy`).
- Reset: state IDLE, HI=0, LO=0, accumulator=0, count=0, `busy`=0, `done`=0. Reset during RUN/FIN aborts the operation; no HI/LO write occurs.

## Timing
- `start` sampled at edge 0. `busy` = 1 from edge 0 through edge 33; 0 after edge 33.
- Edges 1–32: RUN iterations. Edge 32: enter FIN. Edge 33: HI/LO written, `done` high for the cycle after edge 33 only.
- New `start` accepted at edge 34 earliest (first IDLE cycle); back-to-back throughput is 34 cycles.
- `rd` zero-latency from HI/LO and `hilo_sel`; new product visible on `rd` in the same cycle as `done`.

## Structure
- Package `mdu_pkg`: state enum (IDLE/RUN/FIN), `WIDTH` default, `MUL_ITERS`=32 constant.
- Sub-module `hilo_regs`: the HI/LO pair with two write ports (product write at FIN; mthi/mtlo write in IDLE) and read mux. Engine and FSM stay in `mdu_hilo`.

## Test plan
- Reset, then `hilo_sel`=0/1 -> `rd`=0x00000000 both; `busy`=0, `done`=0.
- MULTU a=0x00000003, b=0x00000002 at edge 0 -> `done` after edge 33; LO=0x00000006, HI=0x00000000; `busy` high exactly edges 0–33.
- MULT a=0xFFFFFFFD (-3), b=0x00000002 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULT 0x80000000 × 0x80000000 -> HI=0x40000000, LO=0x00000000.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- mthi wd=0x12345678 in IDLE -> HI=0x12345678; then MULTU 5×5 with `hi_we`=1 and `start` mid-RUN -> second `start` and write ignored, HI=0, LO=0x19 at `done`.
- `rst` asserted at cycle 10 of a multiply (HI preloaded 0xAAAAAAAA) -> next cycle IDLE, `busy`=0, HI=LO=0, no `done` pulse.
